// File: rtl/dcache_wb_dm_if.sv
// Bus bundle for the direct-mapped write-back data cache.
// slave: cache side (processor request in, memory request out); master: its environment.
interface dcache_wb_dm_if;
   logic         proc_read;
   logic         proc_write;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_wdata;
   logic         proc_stall;
   logic [31:0]  proc_rdata;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;

   modport slave (
      input  proc_read, proc_write, proc_addr, proc_wdata,
      input  mem_rdata, mem_ready,
      output proc_stall, proc_rdata,
      output mem_read, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output proc_read, proc_write, proc_addr, proc_wdata,
      output mem_rdata, mem_ready,
      input  proc_stall, proc_rdata,
      input  mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dcache_wb_dm.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines.
// Ports: clk, rst (async high), bus (dcache_wb_dm_if.slave: processor word
// request + 128-bit block memory). Optional hit/miss counters under the
// macro DCACHE_PERF_CNT_EN (adds hit_cnt, miss_cnt outputs).
module dcache_wb_dm #(
   parameter int LINES = 8,
   parameter int IDX_W = 3
) (
   input  logic clk,
   input  logic rst,
   dcache_wb_dm_if.slave bus
`ifdef DCACHE_PERF_CNT_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);
   localparam int TAG_W = 28 - IDX_W;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      ALLOCATE
   } state_e;

   state_e state_q, state_d;

   logic [LINES-1:0] valid_q;
   logic [LINES-1:0] dirty_q;
   logic [TAG_W-1:0] tag_q [LINES];
   logic [127:0]     data_q [LINES];

   logic         mem_read_q, mem_read_d;
   logic         mem_write_q, mem_write_d;
   logic [27:0]  mem_addr_q, mem_addr_d;
   logic [127:0] mem_wdata_q, mem_wdata_d;

   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic [1:0]       woff;
   logic [31:0]      hit_word;
   logic req, hit, stall, fill, wr_hit, miss;

   assign idx      = bus.proc_addr[IDX_W+1:2];
   assign tag      = bus.proc_addr[29:IDX_W+2];
   assign woff     = bus.proc_addr[1:0];
   assign req      = bus.proc_read | bus.proc_write;
   assign hit      = valid_q[idx] & (tag_q[idx] == tag);
   assign hit_word = data_q[idx][{woff, 5'd0} +: 32];

   always_comb begin
      state_d     = state_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      stall       = 1'b0;
      fill        = 1'b0;
      wr_hit      = 1'b0;
      miss        = 1'b0;
      unique case (state_q)
         IDLE: begin
            stall  = req & ~hit;
            wr_hit = bus.proc_write & hit;
            if (req & ~hit) begin
               miss = 1'b1;
               if (valid_q[idx] & dirty_q[idx]) begin
                  state_d     = WRITEBACK;
                  mem_write_d = 1'b1;
                  mem_addr_d  = {tag_q[idx], idx};
                  mem_wdata_d = data_q[idx];
               end else begin
                  state_d    = ALLOCATE;
                  mem_read_d = 1'b1;
                  mem_addr_d = {tag, idx};
               end
            end
         end
         WRITEBACK: begin
            stall = 1'b1;
            if (bus.mem_ready) begin
               state_d     = ALLOCATE;
               mem_write_d = 1'b0;
               mem_read_d  = 1'b1;
               mem_addr_d  = {tag, idx};
            end
         end
         ALLOCATE: begin
            stall = 1'b1;
            if (bus.mem_ready) begin
               state_d    = IDLE;
               mem_read_d = 1'b0;
               fill       = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs read as reset values for as long as rst is held.
   assign bus.proc_stall = stall & ~rst;
   assign bus.proc_rdata =
      (state_q == IDLE && hit && !rst) ? hit_word : 32'd0;
   assign bus.mem_read  = mem_read_q;
   assign bus.mem_write = mem_write_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         valid_q     <= '0;
         dirty_q     <= '0;
      end else begin
         state_q     <= state_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if (fill) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
         end else if (wr_hit) begin
            dirty_q[idx] <= 1'b1;
         end
      end
   end

   // Line payload carries no reset; valid_q alone qualifies it.
   always_ff @(posedge clk) begin
      if (fill && !rst) begin
         data_q[idx] <= bus.mem_rdata;
         tag_q[idx]  <= tag;
      end else if (wr_hit && !rst) begin
         data_q[idx][{woff, 5'd0} +: 32] <= bus.proc_wdata;
      end
   end

`ifdef DCACHE_PERF_CNT_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (state_q == IDLE && req && hit && hit_cnt_q != '1)
            hit_cnt_q <= hit_cnt_q + 32'd1;
         if (miss && miss_cnt_q != '1)
            miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_dcache_wb_dm.sv
// Testbench for dcache_wb_dm: directed scenarios, then randomized traffic
// scored against a flat word-memory model of the cache's visible behaviour.
module tb_dcache_wb_dm;
   logic clk;
   logic rst;

   dcache_wb_dm_if bus();

`ifdef DCACHE_PERF_CNT_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   dcache_wb_dm #(
      .LINES(8),
      .IDX_W(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef DCACHE_PERF_CNT_EN
      ,
      .hit_cnt(hit_cnt),
      .miss_cnt(miss_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        is_read;
      logic [31:0] rdata;
      logic        miss;
      logic        wb;
      logic [27:0] wb_addr;
      logic [27:0] blk;
   } exp_t;

   exp_t sbq[$];
   exp_t me;

   int passed;
   int total;
   logic sb_on, mem_auto, abort;
   logic saw_stall, wb_seen;

   // Reference view: the latest value of every word, plus backing memory.
   logic [31:0]  ref_mem [logic [29:0]];
   logic [127:0] bm      [logic [27:0]];
   logic         cval    [8];
   logic         cdirty  [8];
   logic [24:0]  ctag    [8];

   localparam logic [127:0] BLK_A = {32'hD, 32'hC, 32'hB, 32'hA};
   localparam logic [127:0] BLK_E = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
   localparam logic [127:0] BLK_F = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
   localparam logic [127:0] BLK_G = {32'h73, 32'h72, 32'h71, 32'h70};
   localparam logic [127:0] BLK_H = {32'h83, 32'h82, 32'h81, 32'h80};

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      total++;
      $display("FAIL %s: got event expected none", name);
   endtask

   function automatic logic [31:0] init_word(input logic [29:0] a);
      return {a, 2'b01} ^ 32'h9E37_79B9;
   endfunction

   function automatic logic [31:0] ref_get(input logic [29:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_word(a);
   endfunction

   function automatic logic [127:0] ref_blk(input logic [27:0] b);
      return {ref_get({b, 2'd3}), ref_get({b, 2'd2}),
              ref_get({b, 2'd1}), ref_get({b, 2'd0})};
   endfunction

   function automatic logic [127:0] bm_get(input logic [27:0] b);
      if (bm.exists(b)) return bm[b];
      return {init_word({b, 2'd3}), init_word({b, 2'd2}),
              init_word({b, 2'd1}), init_word({b, 2'd0})};
   endfunction

   task automatic drv(input logic rd, input logic wr,
                      input logic [29:0] a, input logic [31:0] d);
      bus.proc_read  = rd;
      bus.proc_write = wr;
      bus.proc_addr  = a;
      bus.proc_wdata = d;
   endtask

   task automatic issue(input logic rd, input logic wr,
                        input logic [29:0] a, input logic [31:0] d);
      exp_t e;
      int n;
      logic [2:0]  ix;
      logic [24:0] tg;
      ix = a[4:2];
      tg = a[29:5];
      e.miss    = !(cval[ix] && ctag[ix] == tg);
      e.wb      = e.miss && cval[ix] && cdirty[ix];
      e.wb_addr = {ctag[ix], ix};
      e.blk     = a[29:2];
      e.is_read = rd && !wr;
      e.rdata   = ref_get(a);
      if (e.miss) begin
         cval[ix]   = 1'b1;
         ctag[ix]   = tg;
         cdirty[ix] = 1'b0;
      end
      if (wr) begin
         ref_mem[a] = d;
         cdirty[ix] = 1'b1;
      end
      sbq.push_back(e);
      @(posedge clk);
      #1 drv(rd, wr, a, d);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.proc_stall && n < 100);
      if (bus.proc_stall) begin
         chk("req_timeout", bus.proc_stall, 1'b0);
         abort = 1'b1;
      end
   endtask

   // Scoreboard monitor: one entry per accepted processor request.
   initial begin
      forever begin
         @(negedge clk);
         if (sb_on && !rst && (bus.proc_read || bus.proc_write)) begin
            if (bus.proc_stall) begin
               saw_stall = 1'b1;
            end else if (sbq.size() == 0) begin
               fail_now("sb_underflow");
            end else begin
               me = sbq.pop_front();
               chk("miss", saw_stall, me.miss);
               chk("writeback", wb_seen, me.wb);
               if (me.is_read) chk("rdata", bus.proc_rdata, me.rdata);
               saw_stall = 1'b0;
               wb_seen   = 1'b0;
            end
         end
      end
   end

   // Block memory responder with random latency.
   initial begin
      forever begin
         @(negedge clk);
         if (mem_auto && !rst && (bus.mem_read || bus.mem_write)) begin
            chk("mem_excl", bus.mem_read & bus.mem_write, 1'b0);
            if (sbq.size() == 0) begin
               fail_now("mem_no_req");
            end else if (bus.mem_write) begin
               chk("wb_addr", bus.mem_addr, sbq[0].wb_addr);
               chk("wb_data", bus.mem_wdata, ref_blk(bus.mem_addr));
               wb_seen = 1'b1;
            end else begin
               chk("fill_addr", bus.mem_addr, sbq[0].blk);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (bus.mem_write) bm[bus.mem_addr] = bus.mem_wdata;
            else bus.mem_rdata = bm_get(bus.mem_addr);
            bus.mem_ready = 1'b1;
            @(negedge clk);
            bus.mem_ready = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      passed = 0;
      total = 0;
      sb_on = 1'b0;
      mem_auto = 1'b0;
      abort = 1'b0;
      saw_stall = 1'b0;
      wb_seen = 1'b0;
      rst = 1'b1;
      drv(1'b0, 1'b0, 30'd0, 32'd0);
      bus.mem_rdata = '0;
      bus.mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_stall", bus.proc_stall, 1'b0);
      chk("rst_rdata", bus.proc_rdata, 32'd0);
      chk("rst_mrd", bus.mem_read, 1'b0);
      chk("rst_mwr", bus.mem_write, 1'b0);
      chk("rst_maddr", bus.mem_addr, 28'd0);
      chk("rst_mwdata", bus.mem_wdata, 128'd0);
      rst = 1'b0;

      // Read miss into a cold cache.
      drv(1'b1, 1'b0, 30'h10, 32'd0);
      #1 chk("m1_stall", bus.proc_stall, 1'b1);
      chk("m1_mrd_reg", bus.mem_read, 1'b0);
      @(negedge clk);
      chk("m1_mrd", bus.mem_read, 1'b1);
      chk("m1_maddr", bus.mem_addr, 28'h4);
      chk("m1_mwr", bus.mem_write, 1'b0);
      bus.mem_rdata = BLK_A;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      chk("m1_hit_stall", bus.proc_stall, 1'b0);
      chk("m1_rdata", bus.proc_rdata, 32'hA);
      chk("m1_mrd_drop", bus.mem_read, 1'b0);

      // Write hit, then read it back.
      drv(1'b0, 1'b1, 30'h11, 32'h12345678);
      #1 chk("wh_stall", bus.proc_stall, 1'b0);
      @(negedge clk);
      drv(1'b1, 1'b0, 30'h11, 32'd0);
      #1 chk("wh_rdata", bus.proc_rdata, 32'h12345678);

      // Conflict miss on a dirty line: writeback then allocate.
      drv(1'b1, 1'b0, 30'h30, 32'd0);
      #1 chk("wb_stall", bus.proc_stall, 1'b1);
      @(negedge clk);
      chk("wb_mwr", bus.mem_write, 1'b1);
      chk("wb_mrd", bus.mem_read, 1'b0);
      chk("wb_maddr", bus.mem_addr, 28'h4);
      chk("wb_word1", bus.mem_wdata[63:32], 32'h12345678);
      chk("wb_line", bus.mem_wdata,
          {32'hD, 32'hC, 32'h12345678, 32'hA});
      bus.mem_ready = 1'b1;
      @(negedge clk);
      chk("wb_mwr_drop", bus.mem_write, 1'b0);
      chk("wb_al_mrd", bus.mem_read, 1'b1);
      chk("wb_al_maddr", bus.mem_addr, 28'hC);
      bus.mem_rdata = BLK_E;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      chk("wb_done", bus.proc_stall, 1'b0);
      chk("wb_rdata", bus.proc_rdata, 32'hE0);

      // Write miss to a clean line: allocate only, word merged.
      drv(1'b0, 1'b1, 30'h05, 32'hCAFEF00D);
      #1 chk("wm_stall", bus.proc_stall, 1'b1);
      @(negedge clk);
      chk("wm_mrd", bus.mem_read, 1'b1);
      chk("wm_mwr", bus.mem_write, 1'b0);
      chk("wm_maddr", bus.mem_addr, 28'h1);
      bus.mem_rdata = BLK_F;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      chk("wm_hit", bus.proc_stall, 1'b0);
      @(negedge clk);
      drv(1'b1, 1'b0, 30'h05, 32'd0);
      #1 chk("wm_rdata", bus.proc_rdata, 32'hCAFEF00D);
      drv(1'b1, 1'b0, 30'h25, 32'd0);
      #1 chk("ev_stall", bus.proc_stall, 1'b1);
      @(negedge clk);
      chk("ev_mwr", bus.mem_write, 1'b1);
      chk("ev_maddr", bus.mem_addr, 28'h1);
      chk("ev_line", bus.mem_wdata,
          {32'hF3, 32'hF2, 32'hCAFEF00D, 32'hF0});
      bus.mem_ready = 1'b1;
      @(negedge clk);
      chk("ev_al_maddr", bus.mem_addr, 28'h9);
      bus.mem_rdata = BLK_G;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      chk("ev_rdata", bus.proc_rdata, 32'h71);

      // Stray mem_ready on a hit is ignored.
      drv(1'b1, 1'b0, 30'h31, 32'd0);
      bus.mem_ready = 1'b1;
      #1 chk("st_stall", bus.proc_stall, 1'b0);
      chk("st_rdata", bus.proc_rdata, 32'hE1);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      chk("st_mrd", bus.mem_read, 1'b0);
      chk("st_mwr", bus.mem_write, 1'b0);

      // Reset mid-allocate aborts; the line misses again.
      drv(1'b1, 1'b0, 30'h48, 32'd0);
      #1 chk("ab_stall", bus.proc_stall, 1'b1);
      @(negedge clk);
      chk("ab_mrd", bus.mem_read, 1'b1);
      chk("ab_maddr", bus.mem_addr, 28'h12);
      rst = 1'b1;
      #1 chk("ab_rst_mrd", bus.mem_read, 1'b0);
      chk("ab_rst_maddr", bus.mem_addr, 28'd0);
      chk("ab_rst_mwdata", bus.mem_wdata, 128'd0);
      chk("ab_rst_stall", bus.proc_stall, 1'b0);
      chk("ab_rst_rdata", bus.proc_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("ab_remiss", bus.proc_stall, 1'b1);
      @(negedge clk);
      chk("ab_mrd2", bus.mem_read, 1'b1);
      bus.mem_rdata = BLK_H;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      chk("pc_h0", bus.proc_rdata, 32'h80);
      @(negedge clk);
      drv(1'b1, 1'b0, 30'h49, 32'd0);
      #1 chk("pc_h1", bus.proc_rdata, 32'h81);
      @(negedge clk);
      drv(1'b1, 1'b0, 30'h4A, 32'd0);
      #1 chk("pc_h2", bus.proc_rdata, 32'h82);
      @(negedge clk);
      drv(1'b1, 1'b0, 30'h4B, 32'd0);
      #1 chk("pc_h3", bus.proc_rdata, 32'h83);
      @(negedge clk);
      drv(1'b0, 1'b0, 30'd0, 32'd0);
`ifdef DCACHE_PERF_CNT_EN
      #1 chk("hit_cnt", hit_cnt, 32'd4);
      chk("miss_cnt", miss_cnt, 32'd1);
`endif

      // Randomized traffic against the reference model.
      @(negedge clk);
      rst = 1'b1;
      ref_mem.delete();
      bm.delete();
      for (int i = 0; i < 8; i++) begin
         cval[i] = 1'b0;
         cdirty[i] = 1'b0;
         ctag[i] = '0;
      end
      @(negedge clk);
      rst = 1'b0;
      sb_on = 1'b1;
      mem_auto = 1'b1;
      for (int i = 0; i < 400 && !abort; i++) begin
         int op;
         logic [29:0] a;
         op = $urandom_range(0, 9);
         a = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              2'($urandom_range(0, 3))};
         issue(op < 5 || op == 9, op >= 5, a, $urandom());
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1 drv(1'b0, 1'b0, 30'd0, 32'd0);
         end
      end
      @(posedge clk);
      #1 drv(1'b0, 1'b0, 30'd0, 32'd0);
      repeat (3) @(negedge clk);
      chk("sb_drain", sbq.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
